// File: rtl/sisc_exec_core.sv
// SISC execution core: multicycle control FSM, 32-bit ALU with registered
// result and condition codes, and the write-back multiplexer.
//
// state     | meaning
// ----------+------------------------------------------------
// START0    | reset state
// START1    | second start-up cycle
// FETCH     | instruction word becomes valid
// DECODE    | opcode examined, HALT detected
// EXECUTE   | ALU evaluates, result/cc load at end of cycle
// MEM       | status register load enable for ALU ops
// WRITEBACK | register-file write for ALU ops (not CMP)
// HALT      | absorbing until reset
module sisc_exec_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [31:0]      ir,
  input  logic [WIDTH-1:0] rsa,
  input  logic [WIDTH-1:0] rsb,
  input  logic [WIDTH-1:0] read_data,
  input  logic [3:0]       stat,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       cc,
  output logic             stat_en,
  output logic [WIDTH-1:0] write_data,
  output logic             halted
);

  typedef enum logic [2:0] {
    START0    = 3'd0,
    START1    = 3'd1,
    FETCH     = 3'd2,
    DECODE    = 3'd3,
    EXECUTE   = 3'd4,
    MEM       = 3'd5,
    WRITEBACK = 3'd6,
    HALT      = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ALUR = 4'b0001;
  localparam logic [3:0] OP_ALUI = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b0001;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_CMP = 4'b0011;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_XOR = 4'b0110;
  localparam logic [3:0] FN_NOT = 4'b0111;
  localparam logic [3:0] FN_SHL = 4'b1000;
  localparam logic [3:0] FN_SHR = 4'b1001;
  localparam logic [3:0] FN_ASR = 4'b1010;

  state_t state;

  logic [3:0] opcode;
  logic [3:0] mm;
  logic       is_alu;
  logic       is_cmp;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign is_alu = (opcode == OP_ALUR) || (opcode == OP_ALUI);
  assign is_cmp = (mm == FN_CMP);

  // Register fields and the status input are reserved for later revisions.
  logic unused_bits;
  assign unused_bits = ^{stat, ir[23:16]};

  // State sequencing; DECODE diverts to HALT on the halt opcode.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= START0;
    end else begin
      case (state)
        START0:    state <= START1;
        START1:    state <= FETCH;
        FETCH:     state <= DECODE;
        DECODE:    state <= (opcode == OP_HALT) ? HALT : EXECUTE;
        EXECUTE:   state <= MEM;
        MEM:       state <= WRITEBACK;
        WRITEBACK: state <= FETCH;
        HALT:      state <= HALT;
        default:   state <= START0;
      endcase
    end
  end

  // Control enables decoded from the current state and instruction word.
  always_comb begin
    alu_op  = 2'b00;
    stat_en = 1'b0;
    rf_we   = 1'b0;
    halted  = 1'b0;
    case (state)
      EXECUTE:   if (is_alu) alu_op = {opcode == OP_ALUI, 1'b1};
      MEM:       stat_en = is_alu;
      WRITEBACK: rf_we = is_alu && !is_cmp;
      HALT:      halted = 1'b1;
      default:   ;
    endcase
  end

  // No load instructions yet, so write-back always takes the ALU result.
  assign wb_sel = 1'b0;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_next;
  logic             c_next;
  logic             v_next;
  logic             flags_on;
  logic [4:0]       shamt;

  assign b_op  = alu_op[1] ? {{(WIDTH-16){1'b0}}, ir[15:0]} : rsb;
  assign sum   = {1'b0, rsa} + {1'b0, b_op};
  assign diff  = {1'b0, rsa} - {1'b0, b_op};
  assign shamt = b_op[4:0];

  // ALU function select; diff[WIDTH] is the borrow, so C is its inverse.
  always_comb begin
    res_next = rsa;
    c_next   = 1'b0;
    v_next   = 1'b0;
    flags_on = 1'b1;
    case (mm)
      FN_ADD: begin
        res_next = sum[WIDTH-1:0];
        c_next   = sum[WIDTH];
        v_next   = (rsa[WIDTH-1] == b_op[WIDTH-1]) &&
                   (sum[WIDTH-1] != rsa[WIDTH-1]);
      end
      FN_SUB, FN_CMP: begin
        res_next = diff[WIDTH-1:0];
        c_next   = ~diff[WIDTH];
        v_next   = (rsa[WIDTH-1] != b_op[WIDTH-1]) &&
                   (diff[WIDTH-1] != rsa[WIDTH-1]);
      end
      FN_AND:  res_next = rsa & b_op;
      FN_OR:   res_next = rsa | b_op;
      FN_XOR:  res_next = rsa ^ b_op;
      FN_NOT:  res_next = ~rsa;
      FN_SHL:  res_next = rsa << shamt;
      FN_SHR:  res_next = rsa >> shamt;
      FN_ASR:  res_next = $signed(rsa) >>> shamt;
      default: flags_on = 1'b0;
    endcase
  end

  // Result and condition codes capture only on an evaluating EXECUTE cycle.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      alu_result <= '0;
      cc         <= 4'b0000;
    end else if (alu_op[0]) begin
      alu_result <= res_next;
      cc         <= flags_on ? {c_next, v_next, res_next[WIDTH-1], res_next == '0}
                             : 4'b0000;
    end
  end

  assign write_data = wb_sel ? read_data : alu_result;

endmodule

// File: tb/tb_sisc_exec_core.sv
// Self-checking bench for sisc_exec_core using an expected-result queue.
module tb_sisc_exec_core;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic [31:0] ir = 32'h0;
  logic [31:0] rsa = 32'h0;
  logic [31:0] rsb = 32'h0;
  logic [31:0] read_data = 32'h0;
  logic [3:0]  stat = 4'h0;
  logic        rf_we;
  logic        wb_sel;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic [3:0]  cc;
  logic        stat_en;
  logic [31:0] write_data;
  logic        halted;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  cc;
    logic        we;
    logic        imm;
  } exp_t;

  exp_t sb[$];

  sisc_exec_core #(.WIDTH(32)) dut (
    .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb),
    .read_data(read_data), .stat(stat), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_op(alu_op), .alu_result(alu_result), .cc(cc), .stat_en(stat_en),
    .write_data(write_data), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference ALU written from the instruction-set description.
  function automatic exp_t model(input logic [31:0] iw, input logic [31:0] a,
                                 input logic [31:0] rb);
    exp_t e;
    logic [31:0] b;
    logic [32:0] w;
    logic c, v, fl;
    b  = (iw[31:28] == 4'h2) ? {16'h0, iw[15:0]} : rb;
    c  = 1'b0; v = 1'b0; fl = 1'b1;
    e.res = a;
    case (iw[27:24])
      4'h1: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[31:0]; c = w[32];
        v = (a[31] & b[31] & ~e.res[31]) | (~a[31] & ~b[31] & e.res[31]);
      end
      4'h2, 4'h3: begin
        e.res = a - b; c = (a >= b);
        v = (a[31] & ~b[31] & ~e.res[31]) | (~a[31] & b[31] & e.res[31]);
      end
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = a ^ b;
      4'h7: e.res = ~a;
      4'h8: e.res = a << b[4:0];
      4'h9: e.res = a >> b[4:0];
      4'hA: e.res = $unsigned($signed(a) >>> b[4:0]);
      default: fl = 1'b0;
    endcase
    e.cc  = fl ? {c, v, e.res[31], e.res == 32'h0} : 4'h0;
    e.we  = (iw[27:24] != 4'h3);
    e.imm = (iw[31:28] == 4'h2);
    return e;
  endfunction

  task automatic do_reset(input logic [31:0] iw);
    @(negedge clk);
    rst_f = 1'b0;
    ir = iw;
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
  endtask

  // Runs one ALU instruction from FETCH/start, returns at the following FETCH.
  task automatic do_instr(input string nm, input logic [31:0] iw,
                          input logic [31:0] a, input logic [31:0] b,
                          input exp_t e);
    exp_t x;
    bit found = 0;
    ir = iw; rsa = a; rsb = b;
    sb.push_back(e);
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (alu_op[0]) found = 1;
      else if (rf_we !== 1'b0 || stat_en !== 1'b0) begin
        bad++; $display("FAIL %s pre_exec_enables rf_we=%b stat_en=%b want 0", nm, rf_we, stat_en);
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL %s exec_timeout alu_op=%b want x1", nm, alu_op);
      void'(sb.pop_front());
      return;
    end
    total++;
    if (alu_op !== {e.imm, 1'b1}) begin
      bad++; $display("FAIL %s alu_op got=%b want=%b", nm, alu_op, {e.imm, 1'b1});
    end
    @(negedge clk);
    x = sb.pop_front();
    total++;
    if (stat_en !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL %s mem_enables stat_en=%b rf_we=%b want 1/0", nm, stat_en, rf_we);
    end
    total++;
    if (alu_result !== x.res) begin
      bad++; $display("FAIL %s alu_result got=%h want=%h", nm, alu_result, x.res);
    end
    total++;
    if (cc !== x.cc) begin
      bad++; $display("FAIL %s cc got=%b want=%b", nm, cc, x.cc);
    end
    @(negedge clk);
    total++;
    if (rf_we !== x.we || stat_en !== 1'b0 || wb_sel !== 1'b0) begin
      bad++; $display("FAIL %s wb_enables rf_we=%b stat_en=%b wb_sel=%b want %b/0/0", nm, rf_we, stat_en, wb_sel, x.we);
    end
    total++;
    if (write_data !== x.res) begin
      bad++; $display("FAIL %s write_data got=%h want=%h", nm, write_data, x.res);
    end
    @(negedge clk);
    total++;
    if (rf_we !== 1'b0 || alu_op !== 2'b00 || stat_en !== 1'b0) begin
      bad++; $display("FAIL %s fetch_enables rf_we=%b alu_op=%b stat_en=%b want 0", nm, rf_we, alu_op, stat_en);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] c,
                              input logic w, input logic im);
    exp_t e;
    e.res = r; e.cc = c; e.we = w; e.imm = im;
    return e;
  endfunction

  task automatic test_reset;
    int n = 0;
    do_reset(32'h11023000);
    rst_f = 1'b0;
    #1;
    total++;
    if ({rf_we, wb_sel, alu_op, stat_en, halted} !== 6'b0 || alu_result !== 32'h0 || cc !== 4'h0) begin
      bad++; $display("FAIL reset_outputs got=%b/%h/%b want 0", {rf_we, wb_sel, alu_op, stat_en, halted}, alu_result, cc);
    end
    @(negedge clk);
    rst_f = 1'b1;
    rsa = 32'd5; rsb = 32'd7;
    while (n < 10 && !alu_op[0]) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL reset_to_execute cycles got=%0d want=4", n);
    end
  endtask

  task automatic test_add;
    do_reset(32'h11023000);
    do_instr("add", 32'h11023000, 32'd5, 32'd7, mk(32'd12, 4'b0000, 1, 0));
    do_instr("add_again", 32'h11023000, 32'd5, 32'd7, mk(32'd12, 4'b0000, 1, 0));
  endtask

  task automatic test_flags;
    do_instr("sub_zero", 32'h12023000, 32'd5, 32'd5, mk(32'h0, 4'b1001, 1, 0));
    do_instr("add_ovf", 32'h11023000, 32'h7FFFFFFF, 32'd1, mk(32'h80000000, 4'b0110, 1, 0));
    do_instr("addi_wrap", 32'h21020001, 32'hFFFFFFFF, 32'h12345678, mk(32'h0, 4'b1001, 1, 1));
    do_instr("cmp", 32'h13023000, 32'd3, 32'd9, mk(32'hFFFFFFFA, 4'b0010, 0, 0));
    do_instr("pass", 32'h1B023000, 32'h0, 32'd4, mk(32'h0, 4'b0000, 1, 0));
    do_instr("asr", 32'h1A023000, 32'h80000010, 32'd4, mk(32'hF8000001, 4'b0010, 1, 0));
  endtask

  task automatic test_back_to_back;
    logic [31:0] iw, a, b;
    for (int i = 0; i < 24; i++) begin
      iw = {($urandom_range(0, 1) == 1) ? 4'h2 : 4'h1, 4'($urandom_range(0, 11)),
            8'h02, 16'($urandom)};
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      do_instr("rand", iw, a, b, model(iw, a, b));
    end
  endtask

  task automatic test_nop;
    logic [31:0] held;
    held = alu_result;
    ir = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (rf_we !== 0 || stat_en !== 0 || alu_op !== 0 || alu_result !== held) begin
        bad++; $display("FAIL nop cycle%0d en=%b%b%b res=%h want 000/%h", i, rf_we, stat_en, alu_op, alu_result, held);
      end
    end
    ir = 32'h5A023000;
    repeat (7) @(negedge clk);
    total++;
    if (alu_result !== held) begin
      bad++; $display("FAIL nop_other_opcode res=%h want=%h", alu_result, held);
    end
  endtask

  task automatic test_reset_mid_exec;
    int n = 0;
    ir = 32'h11023000; rsa = 32'd5; rsb = 32'd7;
    while (n < 10 && !alu_op[0]) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!alu_op[0]) begin
      bad++; $display("FAIL abort_find_exec alu_op=%b want x1", alu_op);
    end
    rst_f = 1'b0;
    #1;
    total++;
    if (alu_result !== 32'h0 || alu_op !== 2'b00 || cc !== 4'h0) begin
      bad++; $display("FAIL abort_clear res=%h alu_op=%b cc=%b want 0", alu_result, alu_op, cc);
    end
    @(negedge clk);
    rst_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rf_we !== 1'b0 || stat_en !== 1'b0 || alu_op !== 2'b00) begin
        bad++; $display("FAIL abort_no_write cycle%0d rf_we=%b stat_en=%b alu_op=%b want 0", i, rf_we, stat_en, alu_op);
      end
    end
    @(negedge clk);
    total++;
    if (alu_op !== 2'b01) begin
      bad++; $display("FAIL abort_restart alu_op=%b want=01", alu_op);
    end
  endtask

  task automatic test_halt;
    do_reset(32'hF0000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (halted !== 1'b0) begin
        bad++; $display("FAIL halt_early cycle%0d halted=%b want 0", i, halted);
      end
    end
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (i == 5) ir = 32'h11023000;
      total++;
      if (halted !== 1'b1 || rf_we !== 0 || stat_en !== 0 || alu_op !== 0) begin
        bad++; $display("FAIL halt_hold cycle%0d halted=%b en=%b%b%b want 1/000", i, halted, rf_we, stat_en, alu_op);
      end
    end
  endtask

  task automatic test_wb_sel;
    read_data = 32'hDEADBEEF;
    force dut.wb_sel = 1'b1;
    #1;
    total++;
    if (write_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wb_read_data got=%h want=deadbeef", write_data);
    end
    release dut.wb_sel;
    #1;
    total++;
    if (write_data !== alu_result || alu_result === 32'hDEADBEEF) begin
      bad++; $display("FAIL wb_alu got=%h want=%h", write_data, alu_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_back_to_back();
    test_nop();
    test_reset_mid_exec();
    do_reset(32'h11023000);
    do_instr("post_abort", 32'h16023000, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h0FF00FF0, 4'b0000, 1, 0));
    test_wb_sel();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
